// File: rtl/vx_rnd_dispenser.sv
// Shares one PRNG bit stream among NREQ requesters: drops warm-up bits, packs RBITS-wide words, round-robin grants.
// Optional feature macro: VX_RND_DISPENSER_PERF_EN adds perf_grants / perf_stalls counters.
module vx_rnd_dispenser #(
    parameter int NREQ   = 4,
    parameter int NNUM   = 2,
    parameter int RBITS  = 8,
    parameter int WARMUP = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NNUM-1:0]  rnd_in,
    input  logic [NREQ-1:0]  req_valid,
    output logic [NREQ-1:0]  req_ready,
    output logic [RBITS-1:0] rsp_data
`ifdef VX_RND_DISPENSER_PERF_EN
    ,
    output logic [31:0]      perf_grants,
    output logic [31:0]      perf_stalls
`endif
);

    localparam int CNT_W  = $clog2(RBITS + 1);
    localparam int PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WCNT_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_FILL   = 2'd1,
        ST_READY  = 2'd2
    } state_t;

    localparam state_t RESET_STATE = (WARMUP == 0) ? ST_FILL : ST_WARMUP;

    state_t            state_r;
    state_t            state_s;
    logic [WCNT_W-1:0] warm_cnt_r;
    logic [WCNT_W-1:0] warm_cnt_s;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_s;
    logic [RBITS-1:0]  pool_r;
    logic [RBITS-1:0]  pool_s;
    logic [RBITS-1:0]  pool_shift_s;
    logic [PTR_W-1:0]  rr_ptr_r;
    logic [PTR_W-1:0]  rr_ptr_s;
    logic [PTR_W-1:0]  winner_s;
    logic [PTR_W-1:0]  idx_s;
    logic [NREQ-1:0]   grant_s;
    logic              grant_any_s;

    // When a word is exactly one PRNG beat wide the pool is simply replaced.
    generate
        if (RBITS == NNUM) begin : gen_pool_direct
            assign pool_shift_s = rnd_in;
        end else begin : gen_pool_shift
            assign pool_shift_s = {pool_r[RBITS-NNUM-1:0], rnd_in};
        end
    endgenerate

    // Round-robin arbiter: first valid requester at or after rr_ptr, only while a full word is held.
    always_comb begin
        grant_s     = '0;
        grant_any_s = 1'b0;
        winner_s    = '0;
        idx_s       = '0;
        if ((state_r == ST_READY) && !reset) begin
            for (int i = 0; i < NREQ; i++) begin
                idx_s = PTR_W'((int'(rr_ptr_r) + i) % NREQ);
                if (!grant_any_s && req_valid[idx_s]) begin
                    grant_any_s    = 1'b1;
                    grant_s[idx_s] = 1'b1;
                    winner_s       = idx_s;
                end else begin
                end
            end
        end else begin
        end
    end

    // Pointer advances past the winner so every requester waits at most NREQ words.
    always_comb begin
        rr_ptr_s = rr_ptr_r;
        if (grant_any_s) begin
            rr_ptr_s = PTR_W'((int'(winner_s) + 1) % NREQ);
        end else begin
        end
    end

    // Next-state: warm-up countdown, then fill accounting; a grant keeps only the bits shifted in this cycle.
    always_comb begin
        state_s    = state_r;
        warm_cnt_s = warm_cnt_r;
        count_s    = count_r;
        pool_s     = pool_r;
        case (state_r)
            ST_WARMUP: begin
                if (int'(warm_cnt_r) == WARMUP - 1) begin
                    state_s    = ST_FILL;
                    warm_cnt_s = '0;
                end else begin
                    warm_cnt_s = warm_cnt_r + WCNT_W'(1);
                end
            end
            ST_FILL, ST_READY: begin
                pool_s = pool_shift_s;
                if (grant_any_s) begin
                    count_s = CNT_W'(NNUM);
                end else if (int'(count_r) + NNUM >= RBITS) begin
                    count_s = CNT_W'(RBITS);
                end else begin
                    count_s = count_r + CNT_W'(NNUM);
                end
                if (count_s == CNT_W'(RBITS)) begin
                    state_s = ST_READY;
                end else begin
                    state_s = ST_FILL;
                end
            end
            default: begin
                state_s    = RESET_STATE;
                warm_cnt_s = '0;
                count_s    = '0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= RESET_STATE;
            warm_cnt_r <= '0;
            count_r    <= '0;
            pool_r     <= '0;
            rr_ptr_r   <= '0;
        end else begin
            state_r    <= state_s;
            warm_cnt_r <= warm_cnt_s;
            count_r    <= count_s;
            pool_r     <= pool_s;
            rr_ptr_r   <= rr_ptr_s;
        end
    end

    assign req_ready = grant_s;
    assign rsp_data  = pool_r;

`ifdef VX_RND_DISPENSER_PERF_EN
    // Performance counters: grants, and cycles where someone waits without being served.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_grants <= 32'd0;
            perf_stalls <= 32'd0;
        end else if (grant_any_s) begin
            perf_grants <= perf_grants + 32'd1;
        end else if (|req_valid) begin
            perf_stalls <= perf_stalls + 32'd1;
        end else begin
            perf_grants <= perf_grants;
        end
    end
`endif

endmodule
